// File: rtl/vip_unpack_stream_adapter.sv
// Wide-word to pixel unpacker with valid/ready on both sides.
// Supports packed/padded layouts and optional per-line realignment.
module vip_unpack_stream_adapter #(
  parameter int DATA_WIDTH_IN  = 128,
  parameter int DATA_WIDTH_OUT = 24,
  parameter int PACKED         = 1,
  parameter int LINE_WIDTH     = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH_IN-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_WIDTH_OUT-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_eol,
  input  logic [LINE_WIDTH-1:0]     line_length,
  input  logic                      clear
);

  localparam int BUF_W = DATA_WIDTH_IN + DATA_WIDTH_OUT - 1;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int K     = DATA_WIDTH_IN / DATA_WIDTH_OUT;
  localparam int LOAD_BITS =
    (PACKED != 0) ? DATA_WIDTH_IN : K * DATA_WIDTH_OUT;

  localparam logic [CNT_W-1:0] C_OUT  = CNT_W'(DATA_WIDTH_OUT);
  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(LOAD_BITS);
  localparam logic [DATA_WIDTH_IN-1:0] IN_MASK =
    {DATA_WIDTH_IN{1'b1}} >> (DATA_WIDTH_IN - LOAD_BITS);

  logic [BUF_W-1:0]      r_buf;
  logic [CNT_W-1:0]      r_count;
  logic                  r_valid;
  logic [LINE_WIDTH-1:0] r_pix_cnt;
  logic [LINE_WIDTH-1:0] r_len;

  logic [LINE_WIDTH-1:0] w_len;
  logic                  w_len_on;
  logic                  w_eol;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_load;
  logic [CNT_W-1:0]      w_cnt_pp;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [BUF_W-1:0]      w_shift;
  logic [BUF_W-1:0]      w_keep;
  logic [BUF_W-1:0]      w_word;
  logic [BUF_W-1:0]      w_buf_nxt;
  logic [LINE_WIDTH-1:0] w_pix_nxt;

  // Pop/flush/load decisions and next buffer contents.
  always_comb begin
    w_len    = (r_pix_cnt == '0) ? line_length : r_len;
    w_len_on = |w_len;
    w_eol    = r_valid & w_len_on &
               (r_pix_cnt == w_len - LINE_WIDTH'(1));
    w_pop    = r_valid & out_ready;
    w_flush  = w_pop & w_eol;

    w_cnt_pp = r_count;
    w_shift  = r_buf;
    if (w_flush) begin
      w_cnt_pp = '0;
      w_shift  = '0;
    end else if (w_pop) begin
      w_cnt_pp = r_count - C_OUT;
      w_shift  = r_buf >> DATA_WIDTH_OUT;
    end
    w_keep = w_shift & ~({BUF_W{1'b1}} << w_cnt_pp);

    in_ready  = ~clear & (w_cnt_pp < C_OUT);
    w_load    = in_valid & in_ready;
    w_word    = BUF_W'(in_data & IN_MASK);
    w_buf_nxt = w_keep;
    w_cnt_nxt = w_cnt_pp;
    if (w_load) begin
      w_buf_nxt = w_keep | (w_word << w_cnt_pp);
      w_cnt_nxt = w_cnt_pp + C_LOAD;
    end

    w_pix_nxt = r_pix_cnt;
    if (w_flush)
      w_pix_nxt = '0;
    else if (w_pop & w_len_on)
      w_pix_nxt = r_pix_cnt + LINE_WIDTH'(1);
  end

  // Buffer, fill count and line position state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buf     <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_pix_cnt <= '0;
      r_len     <= '0;
    end else if (clear) begin
      r_buf     <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_pix_cnt <= '0;
      r_len     <= '0;
    end else begin
      r_buf     <= w_buf_nxt;
      r_count   <= w_cnt_nxt;
      r_valid   <= (w_cnt_nxt >= C_OUT);
      r_pix_cnt <= w_pix_nxt;
      r_len     <= w_len;
    end
  end

  assign out_data  = r_buf[DATA_WIDTH_OUT-1:0];
  assign out_valid = r_valid;
  assign out_eol   = w_eol;

endmodule

// File: tb/tb_vip_unpack_stream_adapter.sv
// Scoreboard bench for vip_unpack_stream_adapter.
// Instance 0 is packed, instance 1 is padded.
module tb_vip_unpack_stream_adapter;

  localparam int IW = 128;
  localparam int OW = 24;
  localparam int LW = 12;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          e;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic [IW-1:0] in_data     [2];
  logic          in_valid    [2];
  logic          in_ready    [2];
  logic [OW-1:0] out_data    [2];
  logic          out_valid   [2];
  logic          out_ready   [2];
  logic          out_eol     [2];
  logic [LW-1:0] line_length [2];

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  bit   mb0[$];
  bit   mb1[$];
  int   mpc   [2];
  int   n_pop [2];
  int   cyc = 0;
  int   pc_log[$];
  bit          st_on  [2];
  logic [OW:0] st_val [2];
  bit   stim_done;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vip_unpack_stream_adapter #(
      .DATA_WIDTH_IN (IW),
      .DATA_WIDTH_OUT(OW),
      .PACKED        ((g == 0) ? 1 : 0),
      .LINE_WIDTH    (LW)
    ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .in_data    (in_data[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .out_data   (out_data[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_eol    (out_eol[g]),
      .line_length(line_length[g]),
      .clear      (clear)
    );
  end

  initial forever #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic int qsz(input int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Reference: bits of each word (padding dropped) form a
  // stream; pixels are taken 24 bits at a time; a finished
  // line throws away whatever is left of the current word.
  task automatic model_word(input int d, input logic [IW-1:0] w);
    bit   b[$];
    int   lb;
    int   pc;
    int   ll;
    exp_t e;
    if (d == 0) b = mb0;
    else        b = mb1;
    lb = (d == 0) ? IW : (IW / OW) * OW;
    pc = mpc[d];
    ll = int'(line_length[d]);
    for (int i = 0; i < lb; i++) b.push_back(w[i]);
    while (b.size() >= OW) begin
      for (int i = 0; i < OW; i++) e.d[i] = b.pop_front();
      pc++;
      e.e = (ll != 0) && (pc == ll);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      if (e.e) begin
        pc = 0;
        b.delete();
      end
    end
    mpc[d] = pc;
    if (d == 0) mb0 = b;
    else        mb1 = b;
  endtask

  task automatic flush_model();
    q0.delete();
    q1.delete();
    mb0.delete();
    mb1.delete();
    mpc[0] = 0;
    mpc[1] = 0;
  endtask

  task automatic send(input int d, input logic [IW-1:0] w);
    int t   = 0;
    bit acc = 1'b0;
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    while (!acc && t < 300) begin
      @(negedge clock);
      acc = in_ready[d];
      @(posedge clock);
      #1;
      t++;
    end
    in_valid[d] = 1'b0;
    chk("send_accept", 128'(acc), 128'(1));
    if (acc) model_word(d, w);
  endtask

  task automatic send_pix(input int d,
                          input logic [OW-1:0] px[$],
                          input logic [7:0] pad);
    bit            b[$];
    logic [IW-1:0] w;
    foreach (px[i]) begin
      for (int k = 0; k < OW; k++) b.push_back(px[i][k]);
      if (d == 1 && (i % 5) == 4)
        for (int k = 0; k < 8; k++) b.push_back(pad[k]);
    end
    while (b.size() > 0) begin
      w = '0;
      for (int k = 0; k < IW && b.size() > 0; k++)
        w[k] = b.pop_front();
      send(d, w);
    end
  endtask

  task automatic drain(input int d);
    int t = 0;
    while (qsz(d) != 0 && t < 1000) begin
      @(negedge clock);
      t++;
    end
    chk("drain_empty", 128'(qsz(d)), 128'(0));
    @(posedge clock);
    #1;
  endtask

  task automatic clear_all();
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    flush_model();
    @(negedge clock);
    chk("clear_valid0", 128'(out_valid[0]), 128'(0));
    chk("clear_valid1", 128'(out_valid[1]), 128'(0));
    @(posedge clock);
    #1;
  endtask

  function automatic logic [IW-1:0] rword();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: pops the scoreboard on every accepted pixel and
  // checks that stalled outputs hold.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          st_on[d] = 1'b0;
        end else begin
          if (st_on[d])
            chk("stall_hold",
                128'({out_valid[d], out_data[d], out_eol[d]}),
                128'({1'b1, st_val[d]}));
          if (out_valid[d] && out_ready[d]) begin
            n_pop[d]++;
            if (d == 0) pc_log.push_back(cyc);
            if (qsz(d) == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_pixel dut%0d: got=%0h expected=none",
                       d, {out_data[d], out_eol[d]});
            end else begin
              e = qpop(d);
              chk($sformatf("pixel_dut%0d", d),
                  128'({out_data[d], out_eol[d]}), 128'(e));
            end
          end
          st_on[d]  = out_valid[d] & ~out_ready[d] & ~clear;
          st_val[d] = {out_data[d], out_eol[d]};
        end
      end
    end
  end

  logic [OW-1:0] px[$];
  logic [IW-1:0] w;
  int base;

  initial begin : stim
    reset = 1'b1;
    clear = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_data[d]     = '0;
      in_valid[d]    = 1'b0;
      out_ready[d]   = 1'b0;
      line_length[d] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 128'(out_valid[d]), 128'(0));
      chk("rst_data", 128'(out_data[d]), 128'(0));
      chk("rst_eol", 128'(out_eol[d]), 128'(0));
      chk("rst_in_ready", 128'(in_ready[d]), 128'(1));
    end
    @(posedge clock);
    #1;

    // Packed, continuous: pixels 0..15 in three words.
    out_ready[0] = 1'b1;
    base = n_pop[0];
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back(OW'(i));
    send_pix(0, px, 8'h00);
    drain(0);
    chk("s1_count", 128'(n_pop[0] - base), 128'(16));
    if (pc_log.size() >= base + 16)
      chk("s1_span", 128'(pc_log[base + 15] - pc_log[base]),
          128'(15));
    clear_all();

    // Padded: 5 pixels plus 0xFF in the top byte.
    out_ready[1] = 1'b1;
    base = n_pop[1];
    px.delete();
    for (int i = 1; i <= 5; i++) px.push_back(OW'(i));
    send_pix(1, px, 8'hFF);
    drain(1);
    chk("s2_count", 128'(n_pop[1] - base), 128'(5));
    chk("s2_in_ready", 128'(in_ready[1]), 128'(1));
    chk("s2_valid", 128'(out_valid[1]), 128'(0));
    clear_all();

    // Line alignment: 7-pixel lines over padded words.
    line_length[1] = LW'(7);
    out_ready[1] = 1'b1;
    base = n_pop[1];
    px.delete();
    for (int i = 0; i < 15; i++) px.push_back(OW'(i));
    send_pix(1, px, 8'h3C);
    drain(1);
    chk("s3_count", 128'(n_pop[1] - base), 128'(12));
    clear_all();
    line_length[1] = '0;

    // Backpressure: 64 random packed pixels, 30% ready.
    base = n_pop[0];
    px.delete();
    for (int i = 0; i < 64; i++) px.push_back(OW'($urandom));
    stim_done = 1'b0;
    fork
      begin
        send_pix(0, px, 8'h00);
        drain(0);
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clock);
          #1;
          out_ready[0] = ($urandom_range(0, 99) < 30);
        end
      end
    join
    chk("s4_count", 128'(n_pop[0] - base), 128'(64));
    clear_all();

    // Random line length over packed words, 50% ready.
    line_length[0] = LW'($urandom_range(3, 20));
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 15; i++) send(0, rword());
        drain(0);
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clock);
          #1;
          out_ready[0] = ($urandom_range(0, 99) < 50);
        end
      end
    join
    clear_all();
    line_length[0] = '0;

    // Clear after 2 of 5 pixels, then a fresh 7-pixel line.
    line_length[1] = LW'(7);
    base = n_pop[1];
    px.delete();
    for (int i = 0; i < 5; i++) px.push_back(OW'($urandom));
    send_pix(1, px, 8'hA5);
    out_ready[1] = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    out_ready[1] = 1'b0;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    flush_model();
    @(negedge clock);
    chk("s5_valid_after_clear", 128'(out_valid[1]), 128'(0));
    chk("s5_popped", 128'(n_pop[1] - base), 128'(2));
    @(posedge clock);
    #1;
    out_ready[1] = 1'b1;
    px.delete();
    for (int i = 0; i < 10; i++) px.push_back(OW'($urandom));
    send_pix(1, px, 8'h5A);
    drain(1);
    chk("s5_count", 128'(n_pop[1] - base), 128'(9));
    clear_all();
    line_length[1] = '0;

    // Asynchronous reset mid-word.
    send(0, rword());
    out_ready[0] = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    out_ready[0] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("s6_rst_valid", 128'(out_valid[0]), 128'(0));
    chk("s6_rst_data", 128'(out_data[0]), 128'(0));
    chk("s6_rst_eol", 128'(out_eol[0]), 128'(0));
    flush_model();
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("s6_in_ready", 128'(in_ready[0]), 128'(1));
    out_ready[0] = 1'b1;
    base = n_pop[0];
    w = rword();
    send(0, w);
    drain(0);
    chk("s6_count", 128'(n_pop[0] - base), 128'(5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vip_unpack_stream_adapter.md
# vip_unpack_stream_adapter

Parametrised width adapter that converts wide memory words (e.g. 128-bit from the frame-reader master) into narrow pixel words (e.g. 24-bit RGB) for the clocked-video output path. It generalises the earlier pull-style unpacker in three ways:

- valid/ready handshakes on both sides, replacing stall signals;
- packed or padded memory layout;
- optional per-line realignment, which discards residual bits at end of line and flags the last pixel.

## Interface

- DATA_WIDTH_IN, 128, memory word width; must be >= DATA_WIDTH_OUT
- DATA_WIDTH_OUT, 24, pixel word width
- PACKED, 1, 1 = pixels straddle input words; 0 = each word holds floor(IN/OUT) pixels, upper padding ignored
- LINE_WIDTH, 12, width of line_length and of the pixel counter

Ports:

- clock  in  1  clock
- reset  in  1  asynchronous, active-high
- in_data  in  DATA_WIDTH_IN  memory word, first pixel in LSBs
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  DATA_WIDTH_OUT  pixel
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts pixel
- out_eol  out  1  out_data is last pixel of line; qualified by out_valid
- line_length  in  LINE_WIDTH  pixels per line; 0 = no line alignment; sampled only when the pixel counter is 0
- clear  in  1  synchronous flush of all buffered data

## Operation

- Shift buffer: BUF_W = DATA_WIDTH_IN + DATA_WIDTH_OUT - 1 bits, plus a fill count of ceil(log2(BUF_W+1)) bits.
- Valid bits sit LSB-aligned in the buffer.
- pop = out_valid & out_ready. On pop, the buffer shifts right by DATA_WIDTH_OUT and count decreases by DATA_WIDTH_OUT.
- load = in_valid & in_ready. The new word is placed at bit position (count after pop).
  - PACKED=1: count increases by DATA_WIDTH_IN.
  - PACKED=0: count increases by K*DATA_WIDTH_OUT, where K = floor(IN/OUT); padding bits are never output.
- Combinational readiness: in_ready = ~clear & (count - (pop ? OUT : 0) < OUT). in_ready may therefore depend on out_ready in the same cycle.
- Registered validity: out_valid = (count >= OUT); out_data = buffer[OUT-1:0].
- Pixel counter (only active when line_length != 0):
  - Increments on each pop.
  - out_eol = (pixel_cnt == line_length - 1).
  - On pop with out_eol high: pixel_cnt goes to 0 and count goes to 0, discarding the line's residual bits. A load in the same cycle lands at bit 0.
- line_length = 0: out_eol is constantly 0 and data flows continuously.
- clear: count and pixel_cnt go to 0 on the next edge. Clear has priority over pop and load. in_ready is 0 while clear is high. A pop presented during clear is still consumed by the sink but has no effect on state.
- Reset values: count 0, pixel_cnt 0, buffer 0, out_valid 0, out_data 0, out_eol 0. After reset, in_ready is 1 once clear is low.

## Timing

- Latency: a word loaded at edge N produces out_valid at cycle N+1 with its first pixel.
- Throughput: one pixel per cycle sustained while in_valid is held high. Refill happens in the same cycle the last full pixel pops, so there are no bubbles.
- Backpressure: out_data, out_valid and out_eol hold stable while out_valid & ~out_ready.
- Never more than one input word is pending; count <= BUF_W always.
- Reset asserted mid-line returns the block to the empty state asynchronously; no partial pixel is emitted afterwards.

## Test plan

All scenarios use IN=128, OUT=24 unless stated.

- **Packed, continuous:** PACKED=1, line_length=0, three words with pixel values 0..15 → 16 pixels 0..15 on consecutive cycles; none lost or duplicated; in_ready pattern matches count rule.
- **Padded:** PACKED=0, one word with pixels 1..5 in bits [119:0] and 0xFF in bits [127:120] → exactly 5 pixels (1..5); 0xFF never appears; in_ready asserts during the cycle the 5th pixel pops.
- **Line alignment:** PACKED=0, line_length=7, two words holding 0..4 and 5..9 → outputs 0..6 with out_eol on pixel 6; pixels 7..9 discarded; the third word's first pixel follows immediately with pixel_cnt restarted.
- **Backpressure:** random out_ready at 30% duty over 64 packed pixels → output sequence identical to scenario 1's ordering; out_data stable whenever stalled.
- **Clear:** clear pulsed after 2 of 5 pixels have popped → out_valid 0 on the next cycle; the next word's pixel 0 appears next; pixel_cnt restarts, so out_eol position is correct.
- **Reset:** reset asserted mid-word → all outputs 0 immediately; a subsequent word unpacks from its bit 0.
